// File: rtl/dram_cim_bank_array_if.sv
// Request/response bundle between the KV-cache controller and the DRAM CIM bank array.
// cm_popcnt is present only when DRAM_CM_POPCOUNT_EN is defined.
interface dram_cim_bank_array_if #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 10
);
    localparam int unsigned POPCNT_WIDTH = $clog2(DATA_WIDTH) + 1;

    logic                    req_valid;
    logic                    req_ready;
    logic [1:0]              req_op;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   d;
    logic [DATA_WIDTH-1:0]   cm_in;
    logic                    rsp_valid;
    logic                    rsp_is_cm;
    logic [DATA_WIDTH-1:0]   q;
    logic [DATA_WIDTH-1:0]   cm_out;
    logic                    refresh_active;
`ifdef DRAM_CM_POPCOUNT_EN
    logic [POPCNT_WIDTH-1:0] cm_popcnt;
`endif

    modport master (
        output req_valid, req_op, addr, d, cm_in,
`ifdef DRAM_CM_POPCOUNT_EN
        input  cm_popcnt,
`endif
        input  req_ready, rsp_valid, rsp_is_cm, q, cm_out, refresh_active
    );

    modport slave (
        input  req_valid, req_op, addr, d, cm_in,
`ifdef DRAM_CM_POPCOUNT_EN
        output cm_popcnt,
`endif
        output req_ready, rsp_valid, rsp_is_cm, q, cm_out, refresh_active
    );
endinterface

// File: rtl/dram_cim_bank_array.sv
// Multi-bank DRAM macro array: read/write plus compute-in-memory AND/XNOR, bank busy and refresh stalls.
// Optional DRAM_CM_POPCOUNT_EN adds cm_popcnt and one extra response pipeline stage.
module dram_cim_bank_array #(
    parameter int unsigned DATA_WIDTH       = 128,
    parameter int unsigned NUM_BANKS        = 4,
    parameter int unsigned BANK_DEPTH       = 256,
    parameter int unsigned ADDR_WIDTH       = 10,
    parameter int unsigned READ_LATENCY     = 2,
    parameter int unsigned BANK_BUSY        = 3,
    parameter int unsigned REFRESH_INTERVAL = 1024,
    parameter int unsigned REFRESH_CYCLES   = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    dram_cim_bank_array_if.slave   bus
);
    localparam int unsigned BANK_W  = $clog2(NUM_BANKS);
    localparam int unsigned WORDS   = NUM_BANKS * BANK_DEPTH;
    localparam int unsigned BUSY_W  = (BANK_BUSY > 1) ? $clog2(BANK_BUSY) : 1;
    localparam int unsigned REF_MAX = (REFRESH_INTERVAL > REFRESH_CYCLES) ? REFRESH_INTERVAL : REFRESH_CYCLES;
    localparam int unsigned REF_W   = (REF_MAX > 1) ? $clog2(REF_MAX) : 1;
    localparam int unsigned SW      = DATA_WIDTH + 2;
`ifdef DRAM_CM_POPCOUNT_EN
    localparam int unsigned LAT_EFF = READ_LATENCY + 1;
    localparam int unsigned PC_W    = $clog2(DATA_WIDTH) + 1;
`else
    localparam int unsigned LAT_EFF = READ_LATENCY;
`endif

    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_CM_AND  = 2'b10;
    localparam logic [1:0] OP_CM_XNOR = 2'b11;

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_REFRESH = 1'b1;

    logic [0:0]            state, state_nxt;
    logic [REF_W-1:0]      ref_cnt, ref_cnt_nxt;
    logic                  refresh_pending_c;
    logic                  any_busy_c;
    logic                  ready_en;
    logic [BUSY_W-1:0]     busy [NUM_BANKS];
    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic [ADDR_WIDTH-1:0] addr_c;
    logic [BANK_W-1:0]     bank_c;
    logic                  accept_c;
    logic [DATA_WIDTH-1:0] rd_data_c, result_c;
    logic [SW-1:0]         head_c, tail;

    assign addr_c    = bus.addr;
    assign bank_c    = addr_c[BANK_W-1:0];
    assign rd_data_c = mem[addr_c];
    assign bus.req_ready = ready_en & (state == ST_RUN) & ~refresh_pending_c & (busy[bank_c] == '0);
    assign accept_c  = bus.req_valid & bus.req_ready;

    always_comb begin
        any_busy_c = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) any_busy_c = any_busy_c | (busy[b] != '0);
    end

    // Refresh scheduler: counter holds at the last RUN count while waiting for banks to drain.
    always_comb begin
        state_nxt         = state;
        ref_cnt_nxt       = ref_cnt;
        refresh_pending_c = 1'b0;
        case (state)
            ST_RUN: begin
                if (ref_cnt == REF_W'(REFRESH_INTERVAL - 1)) begin
                    refresh_pending_c = 1'b1;
                    if (!any_busy_c) begin
                        state_nxt   = ST_REFRESH;
                        ref_cnt_nxt = '0;
                    end
                end else begin
                    ref_cnt_nxt = ref_cnt + REF_W'(1);
                end
            end
            ST_REFRESH: begin
                if (ref_cnt == REF_W'(REFRESH_CYCLES - 1)) begin
                    state_nxt   = ST_RUN;
                    ref_cnt_nxt = '0;
                end else begin
                    ref_cnt_nxt = ref_cnt + REF_W'(1);
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_RUN;
            ref_cnt            <= '0;
            ready_en           <= 1'b0;
            bus.refresh_active <= 1'b0;
        end else begin
            state              <= state_nxt;
            ref_cnt            <= ref_cnt_nxt;
            ready_en           <= 1'b1;
            bus.refresh_active <= (state_nxt == ST_REFRESH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) busy[b] <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (accept_c && bank_c == BANK_W'(b)) busy[b] <= BUSY_W'(BANK_BUSY - 1);
                else if (busy[b] != '0)               busy[b] <= busy[b] - BUSY_W'(1);
            end
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (accept_c && bus.req_op == OP_WRITE) mem[addr_c] <= bus.d;
    end

    always_comb begin
        result_c = rd_data_c;
        case (bus.req_op)
            OP_CM_AND:  result_c = bus.cm_in & rd_data_c;
            OP_CM_XNOR: result_c = ~(bus.cm_in ^ rd_data_c);
            default:    result_c = rd_data_c;
        endcase
    end

    assign head_c = {accept_c & (bus.req_op != OP_WRITE), bus.req_op[1], result_c};

    // The output register is the last latency stage; earlier stages only exist for latency > 1.
    if (LAT_EFF == 1) begin : g_direct
        assign tail = head_c;
    end else begin : g_pipe
        logic [SW-1:0] stage [LAT_EFF-1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(LAT_EFF) - 1; i++) stage[i] <= '0;
            end else begin
                stage[0] <= head_c;
                for (int i = 1; i < int'(LAT_EFF) - 1; i++) stage[i] <= stage[i-1];
            end
        end
        assign tail = stage[LAT_EFF-2];
    end

`ifdef DRAM_CM_POPCOUNT_EN
    logic [PC_W-1:0] popcnt_c;
    always_comb begin
        popcnt_c = '0;
        for (int i = 0; i < DATA_WIDTH; i++) popcnt_c = popcnt_c + PC_W'(tail[i]);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_is_cm <= 1'b0;
            bus.q         <= '0;
            bus.cm_out    <= '0;
`ifdef DRAM_CM_POPCOUNT_EN
            bus.cm_popcnt <= '0;
`endif
        end else begin
            bus.rsp_valid <= tail[SW-1];
            if (tail[SW-1]) begin
                bus.rsp_is_cm <= tail[SW-2];
                if (tail[SW-2]) begin
                    bus.cm_out    <= tail[DATA_WIDTH-1:0];
`ifdef DRAM_CM_POPCOUNT_EN
                    bus.cm_popcnt <= popcnt_c;
`endif
                end else begin
                    bus.q <= tail[DATA_WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_dram_cim_bank_array.sv
// Directed bench for dram_cim_bank_array: memory ops, bank busy, compute ops, reset and refresh.
// Honours DRAM_CM_POPCOUNT_EN for latency and popcount expectations.
module tb_dram_cim_bank_array;
    localparam int unsigned DW = 128;
    localparam int unsigned AW = 10;
`ifdef DRAM_CM_POPCOUNT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_AND = 2'b10, OP_XNOR = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc;
    int   tests = 0;
    int   fails = 0;

    dram_cim_bank_array_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dram_cim_bank_array #(
        .DATA_WIDTH(DW), .NUM_BANKS(4), .BANK_DEPTH(256), .ADDR_WIDTH(AW),
        .READ_LATENCY(2), .BANK_BUSY(3), .REFRESH_INTERVAL(1024), .REFRESH_CYCLES(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; mirrors nothing in the DUT but the clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send(input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] ci, output int stall);
        bus.req_op    = op;
        bus.addr      = a;
        bus.d         = wd;
        bus.cm_in     = ci;
        bus.req_valid = 1'b1;
        stall = 0;
        #1;
        while (!bus.req_ready && stall < 40) begin
            @(posedge clk); #2;
            stall++;
        end
        if (!bus.req_ready) chk("accept_timeout", DW'(bus.req_ready), DW'(1));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, DW'(bus.rsp_valid), '0);
        chk({tag, "_rsp_is_cm"}, DW'(bus.rsp_is_cm), '0);
        chk({tag, "_q"}, bus.q, '0);
        chk({tag, "_cm_out"}, bus.cm_out, '0);
        chk({tag, "_refresh"}, DW'(bus.refresh_active), '0);
        chk({tag, "_req_ready"}, DW'(bus.req_ready), '0);
`ifdef DRAM_CM_POPCOUNT_EN
        chk({tag, "_popcnt"}, DW'(bus.cm_popcnt), '0);
`endif
    endtask

    initial begin
        int st;
        int lat;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_RD;
        bus.addr      = '0;
        bus.d         = '0;
        bus.cm_in     = '0;

        #12;
        chk_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Write then read the same word: bank busy serialises the read.
        send(OP_WR, 10'h005, {16{8'hA5}}, '0, st);
        chk("t1_wr_stall", DW'(st), DW'(0));
        send(OP_RD, 10'h005, '0, '0, st);
        chk("t1_rd_stall", DW'(st), DW'(2));
        wait_rsp(lat);
        chk("t1_lat", DW'(lat), DW'(LAT));
        chk("t1_q", bus.q, {16{8'hA5}});
        chk("t1_is_cm", DW'(bus.rsp_is_cm), '0);
        @(posedge clk); #1;
        chk("t1_pulse", DW'(bus.rsp_valid), '0);

        // Different banks back to back, then same-bank stall.
        for (int i = 0; i < 4; i++) begin
            send(OP_WR, AW'(i), {16{8'(8'h10 + i)}}, '0, st);
            chk("t2_wr_nostall", DW'(st), DW'(0));
        end
        send(OP_WR, 10'h004, {16{8'h44}}, '0, st);
        chk("t2_wr4_nostall", DW'(st), DW'(0));
        send(OP_WR, 10'h010, {16{8'h55}}, '0, st);
        chk("t2_same_bank_stall", DW'(st), DW'(2));
        send(OP_RD, 10'h002, '0, '0, st);
        wait_rsp(lat);
        chk("t2_rd2_q", bus.q, {16{8'h12}});

        // Compute-in-memory ops.
        send(OP_WR, 10'h020, {8{16'hFF00}}, '0, st);
        send(OP_AND, 10'h020, '0, {8{16'h0FF0}}, st);
        chk("t3_and_stall", DW'(st), DW'(2));
        wait_rsp(lat);
        chk("t3_and_lat", DW'(lat), DW'(LAT));
        chk("t3_and_is_cm", DW'(bus.rsp_is_cm), DW'(1));
        chk("t3_and_cm_out", bus.cm_out, {8{16'h0F00}});
        chk("t3_and_q_hold", bus.q, {16{8'h12}});
`ifdef DRAM_CM_POPCOUNT_EN
        chk("t6_and_popcnt", DW'(bus.cm_popcnt), DW'(32));
`endif
        @(posedge clk); #1;
        send(OP_XNOR, 10'h020, '0, {8{16'h0FF0}}, st);
        wait_rsp(lat);
        chk("t3_xnor_lat", DW'(lat), DW'(LAT));
        chk("t3_xnor_cm_out", bus.cm_out, {8{16'h0F0F}});
`ifdef DRAM_CM_POPCOUNT_EN
        chk("t6_xnor_popcnt", DW'(bus.cm_popcnt), DW'(64));
`endif
        send(OP_RD, 10'h003, '0, '0, st);
        wait_rsp(lat);
        chk("t3_rd3_q", bus.q, {16{8'h13}});
        chk("t3_rd3_is_cm", DW'(bus.rsp_is_cm), '0);
        chk("t3_cm_out_hold", bus.cm_out, {8{16'h0F0F}});
`ifdef DRAM_CM_POPCOUNT_EN
        chk("t6_popcnt_hold", DW'(bus.cm_popcnt), DW'(64));
`endif

        // Reset with a read one cycle into the pipeline.
        send(OP_RD, 10'h020, '0, '0, st);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t5_rst");
        repeat (3) begin
            @(posedge clk); #1;
            chk("t5_rst_norsp", DW'(bus.rsp_valid), '0);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("t5_post_norsp", DW'(bus.rsp_valid), '0);
        end
        send(OP_RD, 10'h005, '0, '0, st);
        wait_rsp(lat);
        chk("t5_retained_q", bus.q, {16{8'hA5}});
        @(posedge clk); #1;

        // Continuous round-robin reads across the first refresh.
        begin
            int unsigned     k = 0;
            logic [DW-1:0]   expq[$];
            int              due[$];
            int              ref_start = -1;
            int              ref_len = 0;
            int              ready_in_ref = 0;
            int              rsp_in_stall = 0;
            int              acc_after = 0;
            int              n_acc = 0;
            int              n_rsp = 0;
            bus.req_op    = OP_RD;
            bus.addr      = AW'(k);
            bus.req_valid = 1'b1;
            #1;
            while (cyc < 1070) begin
                if (bus.rsp_valid) begin
                    n_rsp++;
                    if (due.size() == 0) begin
                        chk("t4_unexpected_rsp", DW'(bus.rsp_valid), '0);
                    end else begin
                        logic [DW-1:0] e;
                        int            dc;
                        e  = expq.pop_front();
                        dc = due.pop_front();
                        if (bus.q !== e)  chk("t4_rsp_q", bus.q, e);
                        if (cyc != dc)    chk("t4_rsp_cycle", DW'(cyc), DW'(dc));
                    end
                end
                if (bus.refresh_active) begin
                    if (ref_start < 0) ref_start = cyc;
                    ref_len++;
                    if (bus.req_ready) ready_in_ref++;
                end
                if (!bus.req_ready && bus.rsp_valid) rsp_in_stall++;
                if (bus.req_valid && bus.req_ready) begin
                    expq.push_back({16{8'(8'h10 + k)}});
                    due.push_back(cyc + LAT);
                    n_acc++;
                    k = (k + 1) % 4;
                    if (ref_start >= 0 && !bus.refresh_active) acc_after++;
                end
                @(posedge clk); #1;
                bus.addr      = AW'(k);
                bus.req_valid = (cyc < 1060);
                #1;
            end
            bus.req_valid = 1'b0;
            chk("t4_ref_window", DW'(ref_start >= 1023 && ref_start <= 1030), DW'(1));
            chk("t4_ref_len", DW'(ref_len), DW'(8));
            chk("t4_ready_in_ref", DW'(ready_in_ref), '0);
            chk("t4_rsp_during_stall", DW'(rsp_in_stall > 0), DW'(1));
            chk("t4_traffic_resumed", DW'(acc_after > 0), DW'(1));
            chk("t4_all_rsp", DW'(n_rsp), DW'(n_acc));
            chk("t4_queue_empty", DW'(due.size()), '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
